pwm_scheduler: RTL and testbench
================================

PWM_SCHEDULER -- requirements
Module: pwm_scheduler

Interface
REQ-001 SHALL have parameter PRESCALE_RESET, default 8'd30, giving the prescale value loaded at reset.
REQ-002 SHALL have one clock; reset is asynchronous and active-low. Ports are clk_i and rst_n_i.
REQ-003 SHALL have the following ports (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- wr_valid_i  in  1  write request
- wr_ready_o  out  1  write accept; transfer occurs when wr_valid_i && wr_ready_o
- wr_addr_i  in  5  0-15 = channel; 16 = mode; 17-31 = reserved
- wr_on_i  in  1  channel full-on; at addr 16, sleep request
- wr_off_i  in  1  channel full-off
- wr_high_i  in  12  channel turn-on count; at addr 16, bits [7:0] = prescale
- wr_low_i  in  12  channel turn-off count
- counter_o  out  12  shared PWM period counter
- pwm_on_o  out  16  active full-on flags, bit n = channel n
- pwm_off_o  out  16  active full-off flags
- pwm_high_o  out  192  active turn-on counts, channel n at [12n+11:12n]
- pwm_low_o  out  192  active turn-off counts, same packing
- period_start_o  out  1  one-cycle pulse on the first cycle of each period
- update_pending_o  out  1  OR of all pending-commit flags
- sleep_o  out  1  sleep state

Function
REQ-004 SHALL keep an 8-bit prescaler that counts 0..P, where P = max(active prescale, 3); on reaching P it wraps to 0 and asserts a tick.
REQ-005 SHALL increment counter_o by 1 on each tick, wrapping from 4095 to 0, so one period equals 4096*(P+1) clocks.
REQ-006 SHALL define the commit cycle as the tick cycle with counter_o == 4095 while awake.
REQ-007 SHALL drive wr_ready_o = 0 in the commit cycle and 1 otherwise; wr_ready_o is combinational from state only.
REQ-008 SHALL, on an accepted write with addr 0-15, store on/off/high/low into that channel's shadow registers and set its pending flag; a rewrite before commit overwrites the shadow (last write wins).
REQ-009 SHALL, on an accepted write with addr 16, store wr_high_i[7:0] into the shadow prescale, set the mode pending flag, and load sleep = wr_on_i immediately.
REQ-010 SHALL accept writes with addr 17-31 and discard them with no state change.
REQ-011 SHALL, at the commit-cycle edge, copy every pending shadow into its active register, clear all pending flags, and set counter_o to 0.
REQ-012 SHALL apply a committed prescale starting with the next prescaler count; the prescaler also restarts at 0.
REQ-013 SHALL, while sleep_o = 1:
- hold the prescaler and counter_o at 0;
- generate no ticks;
- commit pending shadows at the edge after the one that accepted the write;
- drive pwm_off_o as all-ones (forced), with the active registers unchanged.
REQ-014 SHALL, on a wake write (sleep 1->0), begin counting from 0 and assert period_start_o on the first awake cycle.
REQ-015 SHALL assert period_start_o, registered, exactly in the cycle counter_o first equals 0 after wrap or wake, and never while asleep.
REQ-016 SHALL, on a sleep write while awake, immediately zero the counter and prescaler; pending flags are retained and commit under REQ-013.
REQ-017 SHALL treat on/off/high/low fields as opaque; no range check (high > low allowed).

Reset
REQ-018 SHALL, on rst_n_i low, asynchronously clear:
- counter_o, the prescaler and all pending flags to 0;
- active on, high and low to 0; active off to 1 for all channels;
- shadows to the same values as the actives;
- prescale to PRESCALE_RESET; sleep_o to 1; period_start_o to 0.
REQ-019 SHALL drive wr_ready_o = 1 during and after reset, with sleep = 1 and no commit cycle.
REQ-020 SHALL abandon any in-progress period and discard pending writes when reset is asserted mid-operation.

Verification
REQ-021 Reset -> pwm_off_o = 16'hFFFF, sleep_o = 1, counter_o = 0, update_pending_o = 0, wr_ready_o = 1.
REQ-022 Asleep, write ch3 {on 0, off 0, high 100, low 2000} -> pending for 1 cycle, then pwm_high_o[47:36] = 100 and pwm_low_o[47:36] = 2000.
REQ-023 Addr 16 {on 0, high 8'd0} -> effective P = 3; counter_o increments every 4 clocks; period_start_o pulses every 16384 clocks.
REQ-024 Awake, P = 3, write ch0 high = 500 mid-period -> pwm_high_o[11:0] unchanged until the counter wraps 4095->0, then 500; update_pending_o high in between.
REQ-025 wr_valid_i held high across the commit cycle -> wr_ready_o = 0 in exactly that cycle; the write is accepted next cycle and commits in the following period.
REQ-026 rst_n_i asserted mid-period with pending writes -> all outputs return to REQ-018 values immediately, with no commit.

Source files
------------

// File: rtl/pwm_scheduler.sv
// 16-channel PWM register scheduler: shadow registers per channel, committed to the
// active set at period wrap (awake) or on the following edge (asleep).
module pwm_scheduler #(
    parameter logic [7:0] PRESCALE_RESET = 8'd30
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         wr_valid_i,
    output logic         wr_ready_o,
    input  logic [4:0]   wr_addr_i,
    input  logic         wr_on_i,
    input  logic         wr_off_i,
    input  logic [11:0]  wr_high_i,
    input  logic [11:0]  wr_low_i,
    output logic [11:0]  counter_o,
    output logic [15:0]  pwm_on_o,
    output logic [15:0]  pwm_off_o,
    output logic [191:0] pwm_high_o,
    output logic [191:0] pwm_low_o,
    output logic         period_start_o,
    output logic         update_pending_o,
    output logic         sleep_o
);

    localparam logic [4:0] ADDR_MODE = 5'd16;

    logic [7:0]        presc_cnt_q, presc_cnt_d;
    logic [7:0]        prescale_q, prescale_d;
    logic [7:0]        prescale_sh_q, prescale_sh_d;
    logic [11:0]       counter_q, counter_d;
    logic              sleep_q, sleep_d;
    logic              period_start_q, period_start_d;
    logic              mode_pend_q, mode_pend_d;
    logic [15:0]       ch_pend_q, ch_pend_d;
    logic [15:0]       on_q, on_d, on_sh_q, on_sh_d;
    logic [15:0]       off_q, off_d, off_sh_q, off_sh_d;
    logic [15:0][11:0] high_q, high_d, high_sh_q, high_sh_d;
    logic [15:0][11:0] low_q, low_d, low_sh_q, low_sh_d;

    logic [7:0] presc_max;
    logic       tick;
    logic       wrap_commit;
    logic       do_commit;
    logic       wr_fire;
    logic [3:0] wr_ch;

    assign presc_max   = (prescale_q < 8'd3) ? 8'd3 : prescale_q;
    assign tick        = !sleep_q && (presc_cnt_q == presc_max);
    assign wrap_commit = tick && (counter_q == 12'hFFF);
    // While asleep every edge commits, so a pending shadow lands one edge after its write.
    assign do_commit   = wrap_commit || sleep_q;
    assign wr_ready_o  = !wrap_commit;
    assign wr_fire     = wr_valid_i && wr_ready_o;
    assign wr_ch       = wr_addr_i[3:0];

    always_comb begin
        presc_cnt_d    = presc_cnt_q;
        prescale_d     = prescale_q;
        prescale_sh_d  = prescale_sh_q;
        counter_d      = counter_q;
        sleep_d        = sleep_q;
        period_start_d = 1'b0;
        mode_pend_d    = mode_pend_q;
        ch_pend_d      = ch_pend_q;
        on_d           = on_q;
        off_d          = off_q;
        high_d         = high_q;
        low_d          = low_q;
        on_sh_d        = on_sh_q;
        off_sh_d       = off_sh_q;
        high_sh_d      = high_sh_q;
        low_sh_d       = low_sh_q;

        if (do_commit) begin
            for (int i = 0; i < 16; i++) begin
                if (ch_pend_q[i]) begin
                    on_d[i]   = on_sh_q[i];
                    off_d[i]  = off_sh_q[i];
                    high_d[i] = high_sh_q[i];
                    low_d[i]  = low_sh_q[i];
                end
            end
            if (mode_pend_q) begin
                prescale_d = prescale_sh_q;
            end
            ch_pend_d   = '0;
            mode_pend_d = 1'b0;
        end

        if (sleep_q) begin
            presc_cnt_d = '0;
            counter_d   = '0;
        end else if (tick) begin
            presc_cnt_d    = '0;
            counter_d      = counter_q + 12'd1;
            period_start_d = wrap_commit;
        end else begin
            presc_cnt_d = presc_cnt_q + 8'd1;
        end

        if (wr_fire) begin
            if (!wr_addr_i[4]) begin
                on_sh_d[wr_ch]   = wr_on_i;
                off_sh_d[wr_ch]  = wr_off_i;
                high_sh_d[wr_ch] = wr_high_i;
                low_sh_d[wr_ch]  = wr_low_i;
                ch_pend_d[wr_ch] = 1'b1;
            end else if (wr_addr_i == ADDR_MODE) begin
                prescale_sh_d = wr_high_i[7:0];
                mode_pend_d   = 1'b1;
                sleep_d       = wr_on_i;
                if (wr_on_i) begin
                    presc_cnt_d    = '0;
                    counter_d      = '0;
                    period_start_d = 1'b0;
                end else if (sleep_q) begin
                    // Wake: the first awake cycle is the start of a fresh period.
                    presc_cnt_d    = '0;
                    counter_d      = '0;
                    period_start_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            presc_cnt_q    <= '0;
            prescale_q     <= PRESCALE_RESET;
            prescale_sh_q  <= PRESCALE_RESET;
            counter_q      <= '0;
            sleep_q        <= 1'b1;
            period_start_q <= 1'b0;
            mode_pend_q    <= 1'b0;
            ch_pend_q      <= '0;
            on_q           <= '0;
            off_q          <= '1;
            high_q         <= '0;
            low_q          <= '0;
            on_sh_q        <= '0;
            off_sh_q       <= '1;
            high_sh_q      <= '0;
            low_sh_q       <= '0;
        end else begin
            presc_cnt_q    <= presc_cnt_d;
            prescale_q     <= prescale_d;
            prescale_sh_q  <= prescale_sh_d;
            counter_q      <= counter_d;
            sleep_q        <= sleep_d;
            period_start_q <= period_start_d;
            mode_pend_q    <= mode_pend_d;
            ch_pend_q      <= ch_pend_d;
            on_q           <= on_d;
            off_q          <= off_d;
            high_q         <= high_d;
            low_q          <= low_d;
            on_sh_q        <= on_sh_d;
            off_sh_q       <= off_sh_d;
            high_sh_q      <= high_sh_d;
            low_sh_q       <= low_sh_d;
        end
    end

    assign counter_o        = counter_q;
    assign pwm_on_o         = on_q;
    assign pwm_off_o        = sleep_q ? 16'hFFFF : off_q;
    assign pwm_high_o       = high_q;
    assign pwm_low_o        = low_q;
    assign period_start_o   = period_start_q;
    assign update_pending_o = (|ch_pend_q) || mode_pend_q;
    assign sleep_o          = sleep_q;

endmodule

// File: tb/tb_pwm_scheduler.sv
// Scoreboard bench for pwm_scheduler: channel writes push expected active values,
// which are popped and compared when the DUT commits.
module tb_pwm_scheduler;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic         wr_valid_i;
    logic         wr_ready_o;
    logic [4:0]   wr_addr_i;
    logic         wr_on_i;
    logic         wr_off_i;
    logic [11:0]  wr_high_i;
    logic [11:0]  wr_low_i;
    logic [11:0]  counter_o;
    logic [15:0]  pwm_on_o;
    logic [15:0]  pwm_off_o;
    logic [191:0] pwm_high_o;
    logic [191:0] pwm_low_o;
    logic         period_start_o;
    logic         update_pending_o;
    logic         sleep_o;

    pwm_scheduler dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .wr_valid_i      (wr_valid_i),
        .wr_ready_o      (wr_ready_o),
        .wr_addr_i       (wr_addr_i),
        .wr_on_i         (wr_on_i),
        .wr_off_i        (wr_off_i),
        .wr_high_i       (wr_high_i),
        .wr_low_i        (wr_low_i),
        .counter_o       (counter_o),
        .pwm_on_o        (pwm_on_o),
        .pwm_off_o       (pwm_off_o),
        .pwm_high_o      (pwm_high_o),
        .pwm_low_o       (pwm_low_o),
        .period_start_o  (period_start_o),
        .update_pending_o(update_pending_o),
        .sleep_o         (sleep_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          ch;
        logic        on;
        logic        off;
        logic [11:0] hi;
        logic [11:0] lo;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [11:0] slice12(input logic [191:0] v, input int ch);
        return v[ch*12 +: 12];
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic do_write(input logic [4:0] a, input logic on, input logic off,
                            input logic [11:0] hi, input logic [11:0] lo, output int stalls);
        wr_valid_i = 1'b1;
        wr_addr_i  = a;
        wr_on_i    = on;
        wr_off_i   = off;
        wr_high_i  = hi;
        wr_low_i   = lo;
        stalls     = 0;
        while (!wr_ready_o && stalls < 100) begin
            @(negedge clk_i);
            stalls++;
        end
        @(negedge clk_i);
        wr_valid_i = 1'b0;
    endtask

    task automatic ch_write(input int ch, input logic on, input logic off,
                            input logic [11:0] hi, input logic [11:0] lo, output int stalls);
        exp_t e;
        e.ch = ch; e.on = on; e.off = off; e.hi = hi; e.lo = lo;
        exp_q.push_back(e);
        do_write(5'(ch), on, off, hi, lo, stalls);
    endtask

    task automatic sb_pop(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_high"}, slice12(pwm_high_o, e.ch), e.hi);
        check({tag, "_low"}, slice12(pwm_low_o, e.ch), e.lo);
        check({tag, "_on"}, pwm_on_o[e.ch], e.on);
        if (!sleep_o) check({tag, "_off"}, pwm_off_o[e.ch], e.off);
    endtask

    task automatic wait_period(input int budget, output int cyc, output int nready0);
        cyc = 0;
        nready0 = 0;
        do begin
            @(negedge clk_i);
            cyc++;
            if (!wr_ready_o) nready0++;
        end while (!period_start_o && cyc < budget);
        if (!period_start_o) check("period_timeout", 0, 1);
    endtask

    int stalls, cyc, nr0, elapsed;

    initial begin
        rst_n_i    = 1'b0;
        wr_valid_i = 1'b0;
        wr_addr_i  = '0;
        wr_on_i    = 1'b0;
        wr_off_i   = 1'b0;
        wr_high_i  = '0;
        wr_low_i   = '0;

        #12;
        check("rst_off", pwm_off_o, 16'hFFFF);
        check("rst_sleep", sleep_o, 1);
        check("rst_counter", counter_o, 0);
        check("rst_pending", update_pending_o, 0);
        check("rst_ready", wr_ready_o, 1);
        check("rst_pstart", period_start_o, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // Reserved address: no state change, even with on=0.
        do_write(5'd20, 1'b0, 1'b0, 12'h0, 12'h0, stalls);
        check("rsv_pending", update_pending_o, 0);
        check("rsv_sleep", sleep_o, 1);

        // Asleep channel write commits one edge later.
        ch_write(3, 1'b0, 1'b0, 12'd100, 12'd2000, stalls);
        check("sleep_wr_pending", update_pending_o, 1);
        check("sleep_wr_before", slice12(pwm_high_o, 3), 0);
        @(negedge clk_i);
        check("sleep_wr_cleared", update_pending_o, 0);
        sb_pop("ch3");
        check("sleep_off_forced", pwm_off_o, 16'hFFFF);

        // Prescale 0 while staying asleep, then wake.
        do_write(5'd16, 1'b1, 1'b0, 12'h000, 12'h0, stalls);
        @(negedge clk_i);
        check("presc_committed", update_pending_o, 0);
        do_write(5'd16, 1'b0, 1'b0, 12'h000, 12'h0, stalls);
        check("wake_sleep", sleep_o, 0);
        check("wake_pstart", period_start_o, 1);
        check("wake_counter", counter_o, 0);
        check("wake_off", pwm_off_o, 16'hFFF7);
        repeat (4) @(negedge clk_i);
        check("cnt_after4", counter_o, 1);
        check("pstart_low", period_start_o, 0);
        repeat (4) @(negedge clk_i);
        check("cnt_after8", counter_o, 2);
        elapsed = 8;

        // Mid-period write waits for the wrap.
        ch_write(0, 1'b1, 1'b0, 12'd500, 12'd7, stalls);
        elapsed += 1 + stalls;
        check("mid_pending", update_pending_o, 1);
        check("mid_unchanged", slice12(pwm_high_o, 0), 0);
        wait_period(20000, cyc, nr0);
        check("period_len", elapsed + cyc, 16384);
        check("ready_low_cycles", nr0, 1);
        check("wrap_counter", counter_o, 0);
        check("wrap_pending", update_pending_o, 0);
        sb_pop("ch0");

        // Valid held across the commit cycle.
        cyc = 0;
        while (wr_ready_o && cyc < 20000) begin
            @(negedge clk_i);
            cyc++;
        end
        check("commit_cycle_pos", cyc, 16383);
        check("commit_counter", counter_o, 12'hFFF);
        ch_write(5, 1'b0, 1'b1, 12'd1234, 12'd99, stalls);
        check("hold_stalls", stalls, 1);
        check("hold_pending", update_pending_o, 1);
        check("hold_unchanged", slice12(pwm_high_o, 5), 0);
        wait_period(20000, cyc, nr0);
        check("hold_wrap_counter", counter_o, 0);
        sb_pop("ch5");

        // Sleep while awake.
        do_write(5'd16, 1'b1, 1'b0, 12'h000, 12'h0, stalls);
        check("sleep2_sleep", sleep_o, 1);
        check("sleep2_counter", counter_o, 0);
        check("sleep2_off", pwm_off_o, 16'hFFFF);
        check("sleep2_keep_ch0", slice12(pwm_high_o, 0), 500);

        // Reset mid-period with a pending write.
        do_write(5'd16, 1'b0, 1'b0, 12'h000, 12'h0, stalls);
        repeat (10) @(negedge clk_i);
        do_write(5'd2, 1'b0, 1'b0, 12'd77, 12'd88, stalls);
        check("pre_rst_pending", update_pending_o, 1);
        #3 rst_n_i = 1'b0;
        #1;
        check("mrst_off", pwm_off_o, 16'hFFFF);
        check("mrst_sleep", sleep_o, 1);
        check("mrst_counter", counter_o, 0);
        check("mrst_pending", update_pending_o, 0);
        check("mrst_ready", wr_ready_o, 1);
        check("mrst_ch0", slice12(pwm_high_o, 0), 0);
        check("mrst_on", pwm_on_o, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (10) @(negedge clk_i);
        check("post_rst_ch2", slice12(pwm_high_o, 2), 0);
        check("post_rst_pending", update_pending_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
